fpu_arbiter: RTL and testbench

- Shares one multi-cycle FPU (start/done interface, op 00 add, 01 sub, 10 mul, 11 div) among NREQ requesters.
- Accepts one operation at a time and grants requesters in round-robin order.
- Sequences the FPU through start and completion, returns the result tagged with the requester ID, and enforces a completion timeout.
- Sits between the issuing logic and the FPU; it is the only master of the FPU start line.

---
 rtl/fpu_arbiter.sv | 152 +++++++++++++++
 tb/tb_fpu_arbiter.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle start/done FPU among NREQ requesters,
// returning each result tagged with its requester ID and aborting hung operations.
module fpu_arbiter #(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned IDW     = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0]  req_op,
    output logic               fpu_start,
    output logic [31:0]        fpu_a,
    output logic [31:0]        fpu_b,
    output logic [1:0]         fpu_op,
    input  logic               fpu_done,
    input  logic [31:0]        fpu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic               busy
);
    localparam int unsigned TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [TW-1:0]   timer_q;
    logic            fpu_start_q;
    logic [31:0]     fpu_a_q;
    logic [31:0]     fpu_b_q;
    logic [1:0]      fpu_op_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [31:0]     rsp_data_q;
    logic            rsp_err_q;
    logic            busy_q;

    logic [31:0]     a_arr  [NREQ];
    logic [31:0]     b_arr  [NREQ];
    logic [1:0]      op_arr [NREQ];
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  rr_next;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a[g*32 +: 32];
        assign b_arr[g]  = req_b[g*32 +: 32];
        assign op_arr[g] = req_op[g*2 +: 2];
    end

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_valid[IDW'((32'(rr_ptr_q) + k) % NREQ)]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'((32'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    // Ready is combinational so the handshake completes in the grant cycle.
    always_comb begin
        req_ready = '0;
        if (rst && state_q == S_IDLE && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign rr_next = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            fpu_start_q <= 1'b0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fpu_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        fpu_a_q     <= a_arr[grant_id];
                        fpu_b_q     <= b_arr[grant_id];
                        fpu_op_q    <= op_arr[grant_id];
                        rsp_id_q    <= grant_id;
                        fpu_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the last allowed cycle still beats the abort.
                    if (fpu_done) begin
                        rsp_data_q  <= fpu_result;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (timer_q == TW'(TIMEOUT - 2)) begin
                        rsp_data_q  <= QNAN;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_next;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fpu_start = fpu_start_q;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: randomized requesters and FPU latency against a
// round-robin reference model and a behavioural FPU that answers after a set delay.
module tb_fpu_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    logic               clk       = 1'b0;
    logic               rst       = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic               rsp_ready = 1'b1;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*2-1:0]  req_op;
    logic               fpu_start;
    logic [31:0]        fpu_a;
    logic [31:0]        fpu_b;
    logic [1:0]         fpu_op;
    logic               fpu_done;
    logic [31:0]        fpu_result;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               busy;

    logic [31:0] op_a [NREQ];
    logic [31:0] op_b [NREQ];
    logic [1:0]  op_c [NREQ];

    int          n_cmp = 0;
    int          n_err = 0;
    int          rr_m  = 0;
    int          grant_log[$];

    int          fpu_delay  = 3;
    bit          fpu_never  = 1'b0;
    bit          ovr_en     = 1'b0;
    logic [31:0] ovr_val    = '0;
    logic        stray_done = 1'b0;
    logic [31:0] stray_res  = '0;
    logic        mdl_done   = 1'b0;
    logic [31:0] mdl_res    = '0;
    logic [31:0] cap_res    = '0;
    int          fcnt       = 0;
    int          start_cnt  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[g*32 +: 32] = op_a[g];
        assign req_b[g*32 +: 32] = op_b[g];
        assign req_op[g*2 +: 2]  = op_c[g];
    end

    assign fpu_done   = mdl_done | stray_done;
    assign fpu_result = stray_done ? stray_res : mdl_res;

    fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_done(fpu_done), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // Stand-in FPU arithmetic; any fixed function of the operands exposes routing errors.
    function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ {b[15:0], b[31:16]};
            default: return ~(a & b);
        endcase
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] m, input int ptr);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ptr + k) % NREQ;
            if (m[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Behavioural FPU: done pulse fpu_delay cycles after the start pulse.
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (fpu_start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            cap_res   <= ovr_en ? ovr_val : fake_fpu(fpu_a, fpu_b, fpu_op);
            if (!fpu_never) begin
                if (fpu_delay <= 1) begin
                    mdl_done <= 1'b1;
                    mdl_res  <= ovr_en ? ovr_val : fake_fpu(fpu_a, fpu_b, fpu_op);
                end else begin
                    fcnt <= fpu_delay - 1;
                end
            end
        end else if (fcnt > 0) begin
            fcnt <= fcnt - 1;
            if (fcnt == 1 && !fpu_never) begin
                mdl_done <= 1'b1;
                mdl_res  <= cap_res;
            end
        end
    end

    task automatic wait_rsp(input int limit, output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        while (!got && lat < limit) begin
            @(negedge clk); #1;
            lat++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        rr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '1;
        @(negedge clk); #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_cmp++;
        if ({fpu_start, fpu_a, fpu_b, fpu_op} !== '0) begin
            n_err++; $display("FAIL reset_fpu: got start=%b a=%h b=%h op=%b want all 0",
                              fpu_start, fpu_a, fpu_b, fpu_op);
        end
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== '0) begin
            n_err++; $display("FAIL reset_rsp: got v=%b id=%0d d=%h e=%b busy=%b want all 0",
                              rsp_valid, rsp_id, rsp_data, rsp_err, busy);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_no_req: got busy=%b ready=%b rsp_valid=%b want 0/0000/0",
                              busy, req_ready, rsp_valid);
        end
        rr_m = 0;
    endtask

    task automatic test_single();
        bit got;
        int lat;
        int s0;
        ovr_en  = 1'b1;
        ovr_val = 32'h4040_0000;
        fpu_delay = 5;
        op_a[1] = 32'h3F80_0000;
        op_b[1] = 32'h4000_0000;
        op_c[1] = 2'b00;
        s0 = start_cnt;
        req_valid = 4'b0010; #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL single_ready: got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0; #1;
        n_cmp++;
        if (fpu_start !== 1'b1 || fpu_a !== 32'h3F80_0000 || fpu_b !== 32'h4000_0000 ||
            fpu_op !== 2'b00 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_issue: got start=%b a=%h b=%h op=%b busy=%b want 1/3f800000/40000000/00/1",
                              fpu_start, fpu_a, fpu_b, fpu_op, busy);
        end
        wait_rsp(40, got, lat);
        lat++;
        n_cmp++;
        if (!got || lat != 7) begin
            n_err++; $display("FAIL single_latency: got valid=%b at T+%0d want T+7", got, lat);
        end
        n_cmp++;
        if (rsp_id !== 2'd1 || rsp_data !== 32'h4040_0000 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL single_rsp: got id=%0d d=%h e=%b want 1/40400000/0",
                              rsp_id, rsp_data, rsp_err);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || start_cnt - s0 != 1) begin
            n_err++; $display("FAIL single_end: got rsp_valid=%b busy=%b starts=%0d want 0/0/1",
                              rsp_valid, busy, start_cnt - s0);
        end
        ovr_en = 1'b0;
        rr_m = 2;
    endtask

    // Runs n_ops operations from IDLE; refill keeps the granted requester valid afterwards.
    task automatic test_stream(input int n_ops, input logic [NREQ-1:0] mask0,
                               input bit refill, input bit rnd);
        logic [NREQ-1:0] vmask;
        logic [31:0]     ea, eb, er;
        logic [1:0]      eo;
        int              g, lat;
        bit              got, quiet_bad;
        grant_log.delete();
        vmask = mask0;
        for (int op = 0; op < n_ops; op++) begin
            if (rnd) vmask = 4'($urandom_range(15, 1));
            fpu_delay = rnd ? int'($urandom_range(8, 1)) : 3;
            req_valid = vmask; #1;
            g = model_grant(vmask, rr_m);
            n_cmp++;
            if (req_ready !== 4'(1 << g)) begin
                n_err++; $display("FAIL grant op%0d: got ready=%b want %b (mask %b ptr %0d)",
                                  op, req_ready, 4'(1 << g), vmask, rr_m);
            end
            grant_log.push_back(g);
            ea = op_a[g]; eb = op_b[g]; eo = op_c[g];
            er = fake_fpu(ea, eb, eo);
            @(negedge clk);
            if (!refill) vmask[g[1:0]] = 1'b0;
            req_valid = vmask;
            op_a[g] = $urandom; op_b[g] = $urandom; op_c[g] = 2'($urandom);
            #1;
            n_cmp++;
            if (fpu_start !== 1'b1 || fpu_a !== ea || fpu_b !== eb || fpu_op !== eo) begin
                n_err++; $display("FAIL issue op%0d: got start=%b a=%h b=%h op=%b want 1/%h/%h/%b",
                                  op, fpu_start, fpu_a, fpu_b, fpu_op, ea, eb, eo);
            end
            got = 1'b0; lat = 1; quiet_bad = 1'b0;
            while (!got && lat < TIMEOUT + 8) begin
                @(negedge clk); #1;
                lat++;
                if (req_ready !== 4'b0000 || fpu_start !== 1'b0 || fpu_a !== ea) quiet_bad = 1'b1;
                if (rsp_valid === 1'b1) got = 1'b1;
            end
            n_cmp++;
            if (quiet_bad) begin
                n_err++; $display("FAIL busy_quiet op%0d: got ready/start/operand activity while busy want none", op);
            end
            n_cmp++;
            if (!got || lat != fpu_delay + 2) begin
                n_err++; $display("FAIL latency op%0d: got valid=%b at T+%0d want T+%0d",
                                  op, got, lat, fpu_delay + 2);
            end
            n_cmp++;
            if (rsp_id !== 2'(g) || rsp_data !== er || rsp_err !== 1'b0) begin
                n_err++; $display("FAIL rsp op%0d: got id=%0d d=%h e=%b want %0d/%h/0",
                                  op, rsp_id, rsp_data, rsp_err, g, er);
            end
            rr_m = (g + 1) % NREQ;
            @(negedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL rsp_drop op%0d: got rsp_valid=%b busy=%b want 0/0",
                                  op, rsp_valid, busy);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_pair();
        do_reset();
        test_stream(2, 4'b0101, 1'b0, 1'b0);
        n_cmp++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
            n_err++; $display("FAIL pair_order: got %p want 0,2", grant_log);
        end
    endtask

    task automatic test_round_robin();
        bit bad;
        do_reset();
        test_stream(8, 4'b1111, 1'b1, 1'b0);
        bad = (grant_log.size() != 8);
        for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] != i % 4) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_err++; $display("FAIL rr_order: got %p want 0,1,2,3,0,1,2,3", grant_log);
        end
    endtask

    task automatic test_random();
        test_stream(24, 4'b0000, 1'b0, 1'b1);
    endtask

    // Never-done, done on the last WAIT cycle, and done one cycle too late.
    task automatic test_timeout();
        int          dly_tab[3] = '{0, TIMEOUT - 1, TIMEOUT};
        int          r, first;
        bit          exp_err;
        logic [31:0] er;
        for (int i = 0; i < 3; i++) begin
            r = (i + 3) % NREQ;
            fpu_never = (dly_tab[i] == 0);
            fpu_delay = dly_tab[i];
            exp_err = (dly_tab[i] == 0) || (dly_tab[i] >= int'(TIMEOUT));
            op_a[r] = $urandom; op_b[r] = $urandom; op_c[r] = 2'($urandom);
            er = exp_err ? QNAN : fake_fpu(op_a[r], op_b[r], op_c[r]);
            req_valid = 4'(1 << r); #1;
            n_cmp++;
            if (req_ready !== 4'(1 << r)) begin
                n_err++; $display("FAIL to_ready%0d: got %b want %b", i, req_ready, 4'(1 << r));
            end
            @(negedge clk);
            req_valid = '0; #1;
            n_cmp++;
            if (fpu_start !== 1'b1) begin
                n_err++; $display("FAIL to_start%0d: got %b want 1", i, fpu_start);
            end
            first = -1;
            for (int c = 1; c <= int'(TIMEOUT) + 6 && first < 0; c++) begin
                @(negedge clk); #1;
                if (rsp_valid === 1'b1) first = c;
            end
            n_cmp++;
            if (first != int'(TIMEOUT)) begin
                n_err++; $display("FAIL to_latency%0d: got rsp_valid %0d cycles after start want %0d",
                                  i, first, TIMEOUT);
            end
            n_cmp++;
            if (rsp_err !== exp_err || rsp_data !== er || rsp_id !== 2'(r)) begin
                n_err++; $display("FAIL to_rsp%0d: got e=%b d=%h id=%0d want %b/%h/%0d",
                                  i, rsp_err, rsp_data, rsp_id, exp_err, er, r);
            end
            @(negedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL to_idle%0d: got rsp_valid=%b busy=%b want 0/0",
                                  i, rsp_valid, busy);
            end
            rr_m = (r + 1) % NREQ;
            repeat (2) @(negedge clk);
        end
        fpu_never = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] hd, er;
        logic [1:0]  hid;
        logic        he;
        int          g, g2, lat, s0;
        bit          got;
        fpu_delay = 4;
        rsp_ready = 1'b0;
        req_valid = 4'b0011; #1;
        g = model_grant(4'b0011, rr_m);
        er = fake_fpu(op_a[g], op_b[g], op_c[g]);
        n_cmp++;
        if (req_ready !== 4'(1 << g)) begin
            n_err++; $display("FAIL stall_grant: got %b want %b", req_ready, 4'(1 << g));
        end
        @(negedge clk);
        req_valid = 4'b0011 & ~4'(1 << g);
        wait_rsp(TIMEOUT + 8, got, lat);
        n_cmp++;
        if (!got || rsp_id !== 2'(g) || rsp_data !== er) begin
            n_err++; $display("FAIL stall_rsp: got valid=%b id=%0d d=%h want 1/%0d/%h",
                              got, rsp_id, rsp_data, g, er);
        end
        hid = rsp_id; hd = rsp_data; he = rsp_err; s0 = start_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== hid || rsp_data !== hd || rsp_err !== he ||
                req_ready !== 4'b0000 || fpu_start !== 1'b0) begin
                n_err++; $display("FAIL stall_hold c%0d: got v=%b id=%0d d=%h e=%b ready=%b start=%b want 1/%0d/%h/%b/0000/0",
                                  c, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, fpu_start, hid, hd, he);
            end
        end
        n_cmp++;
        if (start_cnt != s0) begin
            n_err++; $display("FAIL stall_starts: got %0d starts during stall want 0", start_cnt - s0);
        end
        rsp_ready = 1'b1;
        rr_m = (g + 1) % NREQ;
        @(negedge clk); #1;
        g2 = model_grant(4'b0011 & ~4'(1 << g), rr_m);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'(1 << g2)) begin
            n_err++; $display("FAIL stall_release: got rsp_valid=%b ready=%b want 0/%b",
                              rsp_valid, req_ready, 4'(1 << g2));
        end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(TIMEOUT + 8, got, lat);
        n_cmp++;
        if (!got || rsp_id !== 2'(g2)) begin
            n_err++; $display("FAIL stall_next: got valid=%b id=%0d want 1/%0d", got, rsp_id, g2);
        end
        rr_m = (g2 + 1) % NREQ;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got;
        int lat;
        fpu_never = 1'b1;
        op_a[2] = 32'hDEAD_BEEF; op_b[2] = 32'h1234_5678; op_c[2] = 2'b11;
        req_valid = 4'b0100;
        repeat (3) @(negedge clk);
        req_valid = 4'b1111;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000 || {fpu_start, fpu_a, fpu_b, fpu_op} !== '0 ||
            {rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: got ready=%b start=%b a=%h b=%h op=%b v=%b id=%0d d=%h e=%b busy=%b want all 0",
                              req_ready, fpu_start, fpu_a, fpu_b, fpu_op, rsp_valid, rsp_id, rsp_data, rsp_err, busy);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        stray_res  = 32'hCAFE_F00D;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL stray_done c%0d: got rsp_valid=%b busy=%b want 0/0",
                                  c, rsp_valid, busy);
            end
        end
        fpu_never = 1'b0;
        fpu_delay = 2;
        rr_m = 0;
        req_valid = 4'b1111; #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL midreset_regrant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(TIMEOUT + 8, got, lat);
        n_cmp++;
        if (!got || rsp_id !== 2'd0 || rsp_err !== 1'b0 ||
            rsp_data !== fake_fpu(op_a[0], op_b[0], op_c[0])) begin
            n_err++; $display("FAIL midreset_op: got valid=%b id=%0d e=%b d=%h want 1/0/0/%h",
                              got, rsp_id, rsp_err, rsp_data, fake_fpu(op_a[0], op_b[0], op_c[0]));
        end
        rr_m = 1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
            op_c[i] = 2'($urandom);
        end
        test_reset();
        test_single();
        test_pair();
        test_round_robin();
        test_random();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1);
    end

endmodule
